mips_multicycle_control: RTL



---
 rtl/mips_ctrl_pkg.sv | 90 +++++++++
 rtl/mips_ctrl_wait_timer.sv | 28 ++
 rtl/mips_multicycle_control.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// States, opcodes, ALU codes, mux selects and the decode helpers.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    R_EXEC,
    R_WB,
    I_EXEC,
    I_WB,
    MEM_ADDR,
    MEM_RD,
    MEM_WB,
    MEM_WR,
    BRANCH,
    JUMP,
    JAL,
    FAULT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_LUI = 3'b110;
  localparam logic [2:0] ALU_R   = 3'b111;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic state_t decode_next(input logic [5:0] op);
    state_t s;
    s = FAULT;
    unique case (1'b1)
      op == OP_RTYPE: s = R_EXEC;
      op == OP_ADDI,
      op == OP_LUI,
      op == OP_ORI,
      op == OP_ANDI:  s = I_EXEC;
      op == OP_LW,
      op == OP_SW:    s = MEM_ADDR;
      op == OP_BEQ,
      op == OP_BNE:   s = BRANCH;
      op == OP_J:     s = JUMP;
      op == OP_JAL:   s = JAL;
      default:        s = FAULT;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    logic [2:0] a;
    a = ALU_ADD;
    unique case (1'b1)
      op == OP_LUI:  a = ALU_LUI;
      op == OP_ORI:  a = ALU_OR;
      op == OP_ANDI: a = ALU_AND;
      default:       a = ALU_ADD;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mips_ctrl_wait_timer.sv
// Memory wait counter: counts stalled cycles, flags expiry
// on the last allowed stalled cycle.
module mips_ctrl_wait_timer #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  // A ready in the same cycle keeps en low, so ready always wins.
  assign expire = en && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM with memory handshake,
// timeout / illegal-opcode fault and retire counter.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W       = 3,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                pc_en_o,
  output logic                iord_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                ir_write_o,
  output logic [1:0]          reg_dst_o,
  output logic [1:0]          mem_to_reg_o,
  output logic                reg_write_o,
  output logic                alu_src_a_o,
  output logic [1:0]          alu_src_b_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic [1:0]          pc_src_o,
  output logic                fault_o,
  output logic [CNT_W-1:0]    retired_o
);

  state_t     state;
  logic       waiting;
  logic       wait_en;
  logic       expire;
  logic       retire;
  logic [2:0] alu3;

  assign waiting = (state == FETCH) || (state == MEM_RD)
                || (state == MEM_WR);
  assign wait_en = waiting && !mem_ready_i;

  mips_ctrl_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .en    (wait_en),
    .clr   (!wait_en),
    .expire(expire)
  );

  always_comb begin
    retire = 1'b0;
    unique case (state)
      R_WB, I_WB, MEM_WB,
      BRANCH, JUMP, JAL: retire = 1'b1;
      MEM_WR:            retire = mem_ready_i;
      default:           retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      retired_o <= '0;
    end else begin
      if (retire) retired_o <= retired_o + CNT_W'(1);
      unique case (state)
        FETCH: begin
          if (expire)           state <= FAULT;
          else if (mem_ready_i) state <= DECODE;
        end
        DECODE:   state <= decode_next(opcode_i);
        R_EXEC:   state <= R_WB;
        I_EXEC:   state <= I_WB;
        MEM_ADDR: state <= (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
        MEM_RD: begin
          if (expire)           state <= FAULT;
          else if (mem_ready_i) state <= MEM_WB;
        end
        MEM_WR: begin
          if (expire)           state <= FAULT;
          else if (mem_ready_i) state <= FETCH;
        end
        R_WB, I_WB, MEM_WB,
        BRANCH, JUMP, JAL: state <= FETCH;
        FAULT:             state <= FAULT;
        default:           state <= FAULT;
      endcase
    end
  end

  always_comb begin
    pc_en_o      = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = DST_RT;
    mem_to_reg_o = WD_ALUOUT;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = SRCB_RT;
    alu3         = 3'b000;
    pc_src_o     = PCS_ALU;
    fault_o      = 1'b0;
    unique case (state)
      FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu3        = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_en_o     = mem_ready_i;
      end
      DECODE: begin
        alu_src_b_o = SRCB_IMMSH;
        alu3        = ALU_ADD;
      end
      R_EXEC: begin
        alu_src_a_o = 1'b1;
        alu3        = ALU_R;
      end
      R_WB: begin
        reg_write_o = 1'b1;
        reg_dst_o   = DST_RD;
      end
      I_EXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu3        = imm_alu_op(opcode_i);
      end
      I_WB: reg_write_o = 1'b1;
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu3        = ALU_ADD;
      end
      MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = WD_MDR;
      end
      MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      BRANCH: begin
        alu_src_a_o = 1'b1;
        alu3        = ALU_SUB;
        pc_src_o    = PCS_ALUOUT;
        pc_en_o     = ((opcode_i == OP_BEQ) && zero_i)
                   || ((opcode_i == OP_BNE) && !zero_i);
      end
      JUMP: begin
        pc_src_o = PCS_JUMP;
        pc_en_o  = 1'b1;
      end
      JAL: begin
        pc_src_o     = PCS_JUMP;
        pc_en_o      = 1'b1;
        reg_write_o  = 1'b1;
        reg_dst_o    = DST_RA;
        mem_to_reg_o = WD_PC;
      end
      FAULT:   fault_o = 1'b1;
      default: fault_o = 1'b1;
    endcase
  end

  assign alu_op_o = ALU_OP_W'(alu3);

endmodule
